fmul_resp_buf: RTL

//  Issue/response shell around the fmul datapath. Accepts operands on a valid/ready port and drives them into fmul.

---
 rtl/fmul_resp_buf.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fmul_resp_buf.sv
// Issue/response shell for the fixed-latency fmul datapath: credit-gated issue,
// valid/tag shift pipe matching fmul latency, and an in-order response FIFO.
module fmul_resp_buf #(
    parameter int DEPTH = 4,
    parameter int LAT   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fmul_a,
    output logic [31:0]      fmul_b,
    output logic             fmul_rstn,
    input  logic [31:0]      fmul_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [LAT-1:0]            vpipe_q, vpipe_d;
    logic [LAT-1:0][TAG_W-1:0] tpipe_q, tpipe_d;
    logic [31:0]               mem_data_q [DEPTH];
    logic [31:0]               mem_data_d [DEPTH];
    logic [TAG_W-1:0]          mem_tag_q  [DEPTH];
    logic [TAG_W-1:0]          mem_tag_d  [DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;

    logic          fire_in, fire_out, wr_en;
    logic [CW-1:0] inflight;
    logic [CW:0]   credits_used;
    logic [7:0]    out_exp;
    logic [22:0]   out_man;

    assign fmul_a    = in_a;
    assign fmul_b    = in_b;
    assign fmul_rstn = ~rst;

    // Every slot is reserved at issue, so a landing product always finds room.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(vpipe_q[i]);
        end
    end

    assign credits_used = {1'b0, count_q} + {1'b0, inflight};
    assign in_ready     = ~rst & (credits_used < (CW+1)'(DEPTH));
    assign fire_in      = in_valid & in_ready;
    assign out_valid    = (count_q != '0);
    assign fire_out     = out_valid & out_ready;
    assign wr_en        = vpipe_q[LAT-1];

    always_comb begin
        vpipe_d    = '0;
        tpipe_d    = '0;
        vpipe_d[0] = fire_in;
        tpipe_d[0] = in_tag;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            tpipe_d[i] = tpipe_q[i-1];
        end
    end

    always_comb begin
        mem_data_d = mem_data_q;
        mem_tag_d  = mem_tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (wr_en) begin
            mem_data_d[wr_ptr_q] = fmul_out;
            mem_tag_d[wr_ptr_q]  = tpipe_q[LAT-1];
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (fire_out) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({wr_en, fire_out})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q  <= '0;
            tpipe_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vpipe_q  <= vpipe_d;
            tpipe_q  <= tpipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_tag_q  <= mem_tag_d;
    end

    assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : 32'h0;
    assign out_tag   = out_valid ? mem_tag_q[rd_ptr_q]  : '0;
    assign out_exp   = out_data[30:23];
    assign out_man   = out_data[22:0];
    assign out_flags = {(out_exp == 8'hFF) & (out_man != '0),
                        (out_exp == 8'hFF) & (out_man == '0),
                        (out_exp == 8'h00) & (out_man == '0)};

endmodule
